instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Producer side of the opcode interface; sits upstream of the main control decoder in the MIPS core.
- Holds the PC and requests instruction words from instruction memory over a req/ready handshake.
- Presents the latched instruction (and its opcode field) to decode/datapath, then accepts the branch/jump outcome.
- Computes the next PC: sequential, branch, or jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
- ADDR_W, 32, PC/address width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory has imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- ir_valid  out  1  ir/op/pc_out hold a valid instruction
- ir  out  32  latched instruction word
- op  out  6  ir[31:26], feeds the control decoder
- pc_out  out  32  address of the instruction in ir
- ir_ack  in  1  downstream has executed ir this cycle
- take_branch  in  1  beq resolved taken (branch & ALU zero)
- jump  in  1  jump control from the decoder

Behaviour:
- Reset is asynchronous and active-low: clock clk, reset rst_n (async, active-low).
  - On reset: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ir=0, op=0, ir_valid=0, pc_out=RESET_PC.
- All outputs are registered.
- IDLE: unconditionally goes to FETCH the next cycle, driving imem_req=1 and imem_addr=pc.
- FETCH:
  - imem_req and imem_addr are held stable until imem_ready is sampled high.
  - On the ready cycle: ir<=imem_rdata, pc_out<=pc, imem_req<=0, ir_valid<=1, state->HOLD.
  - If ready is high on the first request cycle, ir_valid rises one cycle later (1-cycle best-case latency).
- HOLD:
  - ir_valid=1 and ir/op/pc_out remain stable until ir_ack=1.
  - On ir_ack, next pc is selected as:
    - if jump: {pc+4[31:28], ir[25:0], 2'b00}
    - else if take_branch: pc+4 + (sign-extended ir[15:0] << 2)
    - else: pc+4
  - In the same cycle: ir_valid<=0, imem_req<=1, imem_addr<=next pc, state->FETCH.
- Jump and take_branch together: jump wins.
- ir_ack, take_branch and jump are ignored outside HOLD.
- Arithmetic is modulo 2^32:
  - pc+4 at 32'hFFFF_FFFC wraps to 0.
  - A negative branch offset below address 0 wraps.
- imem_addr[1:0] is always 00.
- imem_ready outside FETCH is ignored; imem_rdata is not captured.
- Reset asserted mid-fetch or mid-hold aborts immediately to reset values. There is no residual request.
- Back-to-back throughput is at most 1 instruction per 2 cycles.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output port instr_count (32 bits). It increments on every HOLD-state ir_ack, wraps at 2^32, and resets to 0.
  - Adds output port stall_count (32 bits). It increments on every FETCH cycle with imem_ready=0, wraps, and resets to 0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: R_TYPE=6'd0, J=6'd2, BEQ=6'd4, LW=6'd35, SW=6'd43
  - fetch state encoding: IDLE, FETCH, HOLD
  - default RESET_PC
- One sub-module, next_pc_sel: combinational pc+4, branch target, jump target, and priority mux. It is reused by any later pipelined fetch.

Test Plan:
- Reset release with imem_ready tied 1 -> imem_req rises 1 cycle after IDLE with imem_addr=0; ir_valid=1 the next cycle with ir=imem_rdata and pc_out=0.
- Sequential: ack each instruction with take_branch=0, jump=0 -> imem_addr sequence 0, 4, 8, 0xC.
- beq at pc 0x10 with ir[15:0]=16'hFFFD, take_branch=1 on ack -> next imem_addr=0x08. Same instruction with take_branch=0 -> 0x14.
- j at pc 0x4000_0000 with ir=32'h0800_0040 and jump=1, take_branch=1 -> imem_addr=0x4000_0100 (jump priority).
- Memory wait: imem_ready low for 3 cycles -> imem_req and imem_addr stable for all 4 cycles, ir_valid stays 0. With FETCH_PERF_CNT_EN defined, stall_count=3.
- Wrap, plus reset mid-FETCH with req high:
  - pc=0xFFFF_FFFC acked sequentially -> imem_addr=0.
  - Reset in FETCH -> imem_req=0 immediately; after release, refetch from RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch state encoding, default reset PC.
package mips_pkg;

  localparam logic [5:0] R_TYPE = 6'd0;
  localparam logic [5:0] J      = 6'd2;
  localparam logic [5:0] BEQ    = 6'd4;
  localparam logic [5:0] LW     = 6'd35;
  localparam logic [5:0] SW     = 6'd43;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Word-granular beq offset: sign-extend imm16 and scale by 4.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: pc+4, beq target, j target; jump has priority over branch.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,
  input  logic        jump,
  input  logic        take_branch,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4_s;
  logic [31:0] branch_tgt_s;
  logic [31:0] jump_tgt_s;

  // Candidate targets and priority mux, all modulo 2^32.
  always_comb begin
    pc_plus4_s   = pc + 32'd4;
    branch_tgt_s = pc_plus4_s + branch_offset(instr_index[15:0]);
    jump_tgt_s   = {pc_plus4_s[31:28], instr_index, 2'b00};
    if (jump) begin
      next_pc = jump_tgt_s;
    end else if (take_branch) begin
      next_pc = branch_tgt_s;
    end else begin
      next_pc = pc_plus4_s;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch unit: IDLE/FETCH/HOLD handshake with imem and decode, registered outputs.
// Optional FETCH_PERF_CNT_EN adds instr_count/stall_count performance counters.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              ir_valid,
  output logic [31:0]       ir,
  output logic [5:0]        op,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              ir_ack,
  input  logic              take_branch,
  input  logic              jump
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       instr_count,
  output logic [31:0]       stall_count
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              ir_valid_q, ir_valid_d;
  logic [31:0]       ir_q, ir_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [31:0]       next_pc_s;

  next_pc_sel u_next_pc_sel (
    .pc          (pc_q),
    .instr_index (ir_q[25:0]),
    .jump        (jump),
    .take_branch (take_branch),
    .next_pc     (next_pc_s)
  );

  // Next-state and next-output logic of the fetch FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    ir_valid_d  = ir_valid_q;
    ir_d        = ir_q;
    op_d        = op_q;
    pc_out_d    = pc_out_q;
    case (state_q)
      IDLE: begin
        state_d     = FETCH;
        imem_req_d  = 1'b1;
        imem_addr_d = pc_q;
      end
      FETCH: begin
        if (imem_ready) begin
          state_d    = HOLD;
          ir_d       = imem_rdata;
          op_d       = imem_rdata[31:26];
          pc_out_d   = pc_q;
          imem_req_d = 1'b0;
          ir_valid_d = 1'b1;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      HOLD: begin
        if (ir_ack) begin
          state_d     = FETCH;
          pc_d        = next_pc_s;
          imem_addr_d = next_pc_s;
          imem_req_d  = 1'b1;
          ir_valid_d  = 1'b0;
        end else begin
          ir_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        imem_req_d = 1'b0;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset also drops any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      ir_valid_q  <= 1'b0;
      ir_q        <= 32'd0;
      op_q        <= 6'd0;
      pc_out_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      ir_valid_q  <= ir_valid_d;
      ir_q        <= ir_d;
      op_q        <= op_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign ir_valid  = ir_valid_q;
  assign ir        = ir_q;
  assign op        = op_q;
  assign pc_out    = pc_out_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Retired-instruction and memory-wait counters, both free-running with wrap.
  always_comb begin
    instr_count_d = instr_count_q;
    stall_count_d = stall_count_q;
    if ((state_q == HOLD) && ir_ack) begin
      instr_count_d = instr_count_q + 32'd1;
    end else begin
      instr_count_d = instr_count_q;
    end
    if ((state_q == FETCH) && !imem_ready) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      instr_count_q <= instr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
